// File: rtl/rnd_pkg.sv
// Shared types and constants for the spawn-position sampler.
package rnd_pkg;

  localparam int POS_W         = 10;
  localparam int MAX_POS_DEF   = 530;
  localparam int GRID_LOG2_DEF = 3;

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  // Clears the low grid_log2 bits so positions land on the spawn grid.
  function automatic logic [POS_W-1:0] align_pos(input logic [POS_W-1:0] v,
                                                 input int grid_log2);
    logic [POS_W-1:0] mask;
    mask = '1;
    mask = mask << grid_log2;
    return v & mask;
  endfunction

endpackage

// File: rtl/pos_fifo.sv
// Single-clock position FIFO; full/empty come from an occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module pos_fifo
  import rnd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = POS_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rnd_sampler.sv
// Turns a free-running LFSR value into grid-aligned spawn positions on request.
// Define SAMPLER_NOREPEAT_EN to also reject a position equal to the last accepted one.
module rnd_sampler
  import rnd_pkg::*;
#(
  parameter int MAX_POS   = MAX_POS_DEF,
  parameter int GRID_LOG2 = GRID_LOG2_DEF,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] rnd_in,
  input  logic             req,
  output logic [POS_W-1:0] pos_out,
  output logic             pos_valid,
  output logic             empty,
  output logic             full,
  output logic [7:0]       reject_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [POS_W-1:0] rnd_q;
  logic [POS_W-1:0] cand;
  logic             cand_valid;
  logic [POS_W-1:0] aligned;
  logic             out_of_range;
  logic             is_repeat;
  logic             reject;
  logic             accept;
  logic             push;
  logic             pop;
  logic [POS_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  state_t           state;

  // A new candidate exists only when the generator output has moved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_q      <= '0;
      cand       <= '0;
      cand_valid <= 1'b0;
    end else begin
      rnd_q      <= rnd_in;
      cand       <= rnd_in;
      cand_valid <= (rnd_in != rnd_q);
    end
  end

  assign aligned      = align_pos(cand, GRID_LOG2);
  assign out_of_range = (cand > POS_W'(MAX_POS));

`ifdef SAMPLER_NOREPEAT_EN
  logic [POS_W-1:0] last_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_acc <= 10'h3FF;
    else if (accept) last_acc <= aligned;
  end

  assign is_repeat = (aligned == last_acc);
`else
  assign is_repeat = 1'b0;
`endif

  assign reject = cand_valid && (out_of_range || is_repeat);
  assign accept = cand_valid && !reject;
  assign pop    = !empty && (((state == IDLE) && req) || (state == PEND));
  assign push   = accept && ((fifo_count < CNT_W'(DEPTH)) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                reject_cnt <= '0;
    else if (reject && reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
  end

  pos_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(POS_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (aligned),
    .dout (fifo_head),
    .full (full),
    .empty(empty),
    .count(fifo_count)
  );

  // A request arriving while empty parks in PEND; further requests there are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pos_out   <= '0;
      pos_valid <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      if (pop) begin
        pos_out   <= fifo_head;
        pos_valid <= 1'b1;
      end
      case (state)
        IDLE:    if (req && empty) state <= PEND;
        PEND:    if (!empty)       state <= IDLE;
        default:                   state <= IDLE;
      endcase
    end
  end

endmodule
